// File: rtl/pp_fifo_pkg.sv
// Shared types and helpers for the pp_pipeline_accel SRL stream FIFO.
// Holds the per-cycle operation encoding used by the count/flag control.
package pp_fifo_pkg;

    localparam int PP_FIFO_MIN_DEPTH = 2;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_WR,
        OP_RD,
        OP_RW
    } fifo_op_e;

    function automatic int pp_fifo_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic fifo_op_e pp_fifo_decode_op(input logic wr, input logic rd);
        fifo_op_e op;
        case ({wr, rd})
            2'b10:   op = OP_WR;
            2'b01:   op = OP_RD;
            2'b11:   op = OP_RW;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pp_pipeline_accel_fifo_srl_param_shiftreg.sv
// SRL storage array: a write shifts every entry up by one, the read port is
// an address-indexed tap. Contents are deliberately not reset.
module pp_pipeline_accel_fifo_srl_param_shiftreg #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  ce_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] srl_q [DEPTH];

    always_ff @(posedge clk) begin
        if (ce_i) begin
            srl_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                srl_q[i] <= srl_q[i-1];
            end
        end
    end

    // Addresses past the last entry only occur for non power-of-two depths.
    assign q_o = ({1'b0, addr_i} < DEPTH_C) ? srl_q[addr_i] : '0;

endmodule

// File: rtl/pp_pipeline_accel_fifo_srl_param.sv
// Parametrised SRL stream FIFO with almost flags, flush and sticky error flags.
// Define PP_FIFO_OUT_REG_EN to add a first-word-fall-through output register.
module pp_pipeline_accel_fifo_srl_param
    import pp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_flush,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic                  if_empty_n,
    output logic                  if_almost_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap,
    output logic                  if_err_ovf,
    output logic                  if_err_udf
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
`ifdef PP_FIFO_OUT_REG_EN
    localparam logic [CW-1:0] CAP_C   = CW'(DEPTH + 1);
`else
    localparam logic [CW-1:0] CAP_C   = DEPTH_C;
`endif

    if (DEPTH < PP_FIFO_MIN_DEPTH) begin : g_depth_chk
        $error("DEPTH must be at least 2");
    end
    if (ADDR_WIDTH < pp_fifo_clog2(DEPTH)) begin : g_addr_chk
        $error("ADDR_WIDTH too small for DEPTH");
    end

    logic                  write, read;
    logic                  wr_acc, rd_acc, srl_pop;
    fifo_op_e              op;
    logic [CW-1:0]         cnt_q, cnt_d, occ_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  af_n_q, af_n_d;
    logic                  ae_n_q, ae_n_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [ADDR_WIDTH-1:0] srl_addr;
    logic [DATA_WIDTH-1:0] srl_data;

    assign write = if_write & if_write_ce;
    assign read  = if_read & if_read_ce;

    // A flush swallows any same-cycle transfer, so acceptance is gated here.
    assign wr_acc = write & full_n_q & ~if_flush;
    assign rd_acc = read & empty_n_q & ~if_flush;
`ifdef PP_FIFO_OUT_REG_EN
    assign srl_pop = (~empty_n_q | rd_acc) & (cnt_q != '0) & ~if_flush;
`else
    assign srl_pop = rd_acc;
`endif
    assign op       = pp_fifo_decode_op(wr_acc, srl_pop);
    assign srl_addr = (cnt_q == '0) ? '0 : ADDR_WIDTH'(cnt_q - 1'b1);

    pp_pipeline_accel_fifo_srl_param_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_srl (
        .clk    (clk),
        .ce_i   (wr_acc),
        .data_i (if_din),
        .addr_i (srl_addr),
        .q_o    (srl_data)
    );

    // Flags are computed from the next-state occupancy so they stay registered.
    always_comb begin
        cnt_d = cnt_q;
        case (op)
            OP_WR:   cnt_d = cnt_q + 1'b1;
            OP_RD:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (if_flush) begin
            cnt_d = '0;
        end
`ifdef PP_FIFO_OUT_REG_EN
        empty_n_d = empty_n_q;
        if (srl_pop) begin
            empty_n_d = 1'b1;
        end else if (rd_acc) begin
            empty_n_d = 1'b0;
        end
        if (if_flush) begin
            empty_n_d = 1'b0;
        end
        occ_d = cnt_d + {{ADDR_WIDTH{1'b0}}, empty_n_d};
`else
        empty_n_d = (cnt_d != '0);
        occ_d     = cnt_d;
`endif
        full_n_d = (cnt_d != DEPTH_C);
        af_n_d   = !(occ_d >= AF_C);
        ae_n_d   = !(occ_d <= AE_C);
        ovf_d    = ovf_q | (write & ~full_n_q & ~if_flush);
        udf_d    = udf_q | (read & ~empty_n_q & ~if_flush);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            af_n_q    <= 1'b1;
            ae_n_q    <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            af_n_q    <= af_n_d;
            ae_n_q    <= ae_n_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

`ifdef PP_FIFO_OUT_REG_EN
    logic [DATA_WIDTH-1:0] dout_q;

    // empty_n_q doubles as the output-register valid bit in this build.
    always_ff @(posedge clk) begin
        if (srl_pop) begin
            dout_q <= srl_data;
        end
    end

    assign if_dout           = dout_q;
    assign if_num_data_valid = cnt_q + {{ADDR_WIDTH{1'b0}}, empty_n_q};
`else
    assign if_dout           = srl_data;
    assign if_num_data_valid = cnt_q;
`endif

    assign if_full_n         = full_n_q;
    assign if_empty_n        = empty_n_q;
    assign if_almost_full_n  = af_n_q;
    assign if_almost_empty_n = ae_n_q;
    assign if_fifo_cap       = CAP_C;
    assign if_err_ovf        = ovf_q;
    assign if_err_udf        = udf_q;

endmodule
